// File: rtl/i2c_init_pkg.sv
// ---------------------------------------------------------------------------
// i2c_init_pkg
// Shared definitions for the I2C init sequencer:
//   - entry field widths and packed entry layout
//     {dev_addr[22:16], reg_addr[15:8], reg_data[7:0]}
//   - default table length and the default table itself (init_entry)
//   - sequencer FSM state encoding
// ---------------------------------------------------------------------------
package i2c_init_pkg;

    localparam int DEV_W        = 7;
    localparam int REG_W        = 8;
    localparam int DAT_W        = 8;
    localparam int ENTRY_W_DEF  = DEV_W + REG_W + DAT_W;
    localparam int INIT_LEN_DEF = 4;
    // Index register is sized for the largest supported table (256 entries).
    localparam int IDX_W        = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_REG  = 2'd2,
        ST_DAT  = 2'd3
    } state_t;

    // Default table: device 0x50, register i receives 1 << i.
    // Indices outside the table return all zeros.
    function automatic logic [ENTRY_W_DEF-1:0] init_entry(input logic [IDX_W-1:0] idx);
        logic [ENTRY_W_DEF-1:0] e;
        case (idx)
            8'd0:    e = {7'h50, 8'h00, 8'h01};
            8'd1:    e = {7'h50, 8'h01, 8'h02};
            8'd2:    e = {7'h50, 8'h02, 8'h04};
            8'd3:    e = {7'h50, 8'h03, 8'h08};
            default: e = '0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/i2c_init_rom.sv
// ---------------------------------------------------------------------------
// i2c_init_rom
// Combinational table lookup: entry index -> packed table entry.
// Kept separate from the sequencer so a product-specific table can be
// swapped in without touching the FSM.
// Ports:
//   i_idx    in   IDX_W    table index
//   o_entry  out  ENTRY_W  {dev_addr, reg_addr, reg_data}
// ---------------------------------------------------------------------------
module i2c_init_rom
    import i2c_init_pkg::*;
#(
    parameter int ENTRY_W = ENTRY_W_DEF
) (
    input  logic [IDX_W-1:0]   i_idx,
    output logic [ENTRY_W-1:0] o_entry
);

    assign o_entry = ENTRY_W'(init_entry(i_idx));

endmodule

// File: rtl/i2c_init_sequencer.sv
// ---------------------------------------------------------------------------
// i2c_init_sequencer
// Replays a fixed table of I2C register writes into an I2C master core.
// Each entry becomes one write_multiple+stop command to dev_addr followed by
// two data bytes: reg_addr (tlast=0) then reg_data (tlast=1).
//
// Handshake (both AXI-stream channels): a transfer happens on a posedge
// where valid and ready are both 1. Once valid rises, valid and its payload
// hold until that transfer. ready may be high before valid. The cmd and data
// channels are never valid in the same cycle.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   start                       rising edge (seen in IDLE) starts one pass
//   busy                        high while a pass is in progress
//   m_axis_cmd_*                command channel to the I2C master
//   m_axis_data_*               write-data channel to the I2C master
//   dbg_state                   current FSM state (state_t encoding)
// ---------------------------------------------------------------------------
module i2c_init_sequencer
    import i2c_init_pkg::*;
#(
    parameter int INIT_LEN = INIT_LEN_DEF,
    parameter int ENTRY_W  = ENTRY_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic [DEV_W-1:0] m_axis_cmd_address,
    output logic             m_axis_cmd_start,
    output logic             m_axis_cmd_read,
    output logic             m_axis_cmd_write,
    output logic             m_axis_cmd_write_multiple,
    output logic             m_axis_cmd_stop,
    output logic             m_axis_cmd_valid,
    input  logic             m_axis_cmd_ready,
    output logic [DAT_W-1:0] m_axis_data_tdata,
    output logic             m_axis_data_tvalid,
    input  logic             m_axis_data_tready,
    output logic             m_axis_data_tlast,
    output logic [1:0]       dbg_state
);

    state_t             r_state;
    state_t             w_state_next;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_next;
    logic               r_start_d;
    logic               r_busy;
    logic               r_cmd_valid;
    logic [DEV_W-1:0]   r_cmd_address;
    logic               r_tvalid;
    logic [DAT_W-1:0]   r_tdata;
    logic               r_tlast;

    logic               w_start_edge;
    logic               w_last_entry;
    logic [ENTRY_W-1:0] w_entry;
    logic [DEV_W-1:0]   w_dev;
    logic [REG_W-1:0]   w_reg;
    logic [DAT_W-1:0]   w_dat;

    assign w_start_edge = start & ~r_start_d;
    assign w_last_entry = (r_idx == IDX_W'(INIT_LEN - 1));

    // Look up the entry for the *next* index so the registered payload is
    // already correct in the cycle the FSM enters CMD/REG/DAT.
    i2c_init_rom #(
        .ENTRY_W (ENTRY_W)
    ) u_rom (
        .i_idx   (w_idx_next),
        .o_entry (w_entry)
    );

    assign w_dev = w_entry[ENTRY_W-1 -: DEV_W];
    assign w_reg = w_entry[REG_W+DAT_W-1 -: REG_W];
    assign w_dat = w_entry[DAT_W-1:0];

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        case (r_state)
            ST_IDLE: begin
                if (w_start_edge) begin
                    w_idx_next   = '0;
                    w_state_next = ST_CMD;
                end
            end
            // valid is held high in CMD/REG/DAT, so ready alone marks a transfer.
            ST_CMD: begin
                if (m_axis_cmd_ready) w_state_next = ST_REG;
            end
            ST_REG: begin
                if (m_axis_data_tready) w_state_next = ST_DAT;
            end
            ST_DAT: begin
                if (m_axis_data_tready) begin
                    if (w_last_entry) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_idx_next   = r_idx + 1'b1;
                        w_state_next = ST_CMD;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state, so they change on the same
    // edge as the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_idx         <= '0;
            r_start_d     <= 1'b0;
            r_busy        <= 1'b0;
            r_cmd_valid   <= 1'b0;
            r_cmd_address <= '0;
            r_tvalid      <= 1'b0;
            r_tdata       <= '0;
            r_tlast       <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_idx         <= w_idx_next;
            r_start_d     <= start;
            r_busy        <= (w_state_next != ST_IDLE);
            r_cmd_valid   <= (w_state_next == ST_CMD);
            r_cmd_address <= (w_state_next == ST_CMD) ? w_dev : '0;
            r_tvalid      <= (w_state_next == ST_REG) || (w_state_next == ST_DAT);
            r_tdata       <= (w_state_next == ST_REG) ? w_reg :
                             (w_state_next == ST_DAT) ? w_dat : '0;
            r_tlast       <= (w_state_next == ST_DAT);
        end
    end

    assign busy                      = r_busy;
    assign m_axis_cmd_address        = r_cmd_address;
    assign m_axis_cmd_start          = 1'b0;
    assign m_axis_cmd_read           = 1'b0;
    assign m_axis_cmd_write          = 1'b0;
    // Every command is a multi-byte write ending in stop.
    assign m_axis_cmd_write_multiple = r_cmd_valid;
    assign m_axis_cmd_stop           = r_cmd_valid;
    assign m_axis_cmd_valid          = r_cmd_valid;
    assign m_axis_data_tdata         = r_tdata;
    assign m_axis_data_tvalid        = r_tvalid;
    assign m_axis_data_tlast         = r_tlast;
    assign dbg_state                 = r_state;

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// ---------------------------------------------------------------------------
// tb_i2c_init_sequencer
// Self-checking bench. A queue of expected channel beats is filled whenever
// an accepted start edge is seen; beats are popped on handshakes and the
// front of the queue must match the DUT outputs every cycle.
// Beat encoding (10 bits): {is_cmd, tlast, payload[7:0]}.
// ---------------------------------------------------------------------------
module tb_i2c_init_sequencer;

  localparam int N_ENT = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start = 1'b0;
  logic       cmd_ready = 1'b0;
  logic       tready = 1'b0;
  logic       busy;
  logic [6:0] cmd_address;
  logic       cmd_start, cmd_read, cmd_write, cmd_wm, cmd_stop, cmd_valid;
  logic [7:0] tdata;
  logic       tvalid, tlast;
  logic [1:0] dbg_state;

  i2c_init_sequencer dut (
    .clk                       (clk),
    .rst                       (rst),
    .start                     (start),
    .busy                      (busy),
    .m_axis_cmd_address        (cmd_address),
    .m_axis_cmd_start          (cmd_start),
    .m_axis_cmd_read           (cmd_read),
    .m_axis_cmd_write          (cmd_write),
    .m_axis_cmd_write_multiple (cmd_wm),
    .m_axis_cmd_stop           (cmd_stop),
    .m_axis_cmd_valid          (cmd_valid),
    .m_axis_cmd_ready          (cmd_ready),
    .m_axis_data_tdata         (tdata),
    .m_axis_data_tvalid        (tvalid),
    .m_axis_data_tready        (tready),
    .m_axis_data_tlast         (tlast),
    .dbg_state                 (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;
  int rdy_mode = 0;          // 0: ready tied high, 1: ~30% random, 2: hold
  int cmd_xfers = 0;
  int busy_rises = 0;
  logic busy_prev = 1'b0;
  logic model_start_d = 1'b0;
  bit model_idle_pre;
  logic [9:0] exp_q[$];
  logic [8:0] cap_q[$];
  logic [8:0] lit_stream[8];
  logic [9:0] front;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // One pass of the default table: device 0x50, register i <- (1 << i).
  task automatic push_pass();
    for (int i = 0; i < N_ENT; i++) begin
      exp_q.push_back({1'b1, 1'b0, 1'b0, 7'h50});
      exp_q.push_back({1'b0, 1'b0, 8'(i)});
      exp_q.push_back({1'b0, 1'b1, 8'(1 << i)});
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      model_start_d = 1'b0;
    end else begin
      model_idle_pre = (exp_q.size() == 0);
      if (cmd_valid && cmd_ready) begin
        cmd_xfers++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (tvalid && tready) begin
        cap_q.push_back({tlast, tdata});
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (start && !model_start_d && model_idle_pre) push_pass();
      model_start_d = start;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy", busy, exp_q.size() != 0);
      check("cmd_fixed_zero", {cmd_start, cmd_read, cmd_write}, 3'b000);
      check("cmd_wm_stop", {cmd_wm, cmd_stop}, {cmd_valid, cmd_valid});
      if (exp_q.size() != 0) begin
        front = exp_q[0];
        check("cmd_valid", cmd_valid, front[9]);
        check("tvalid", tvalid, !front[9]);
        if (front[9]) check("cmd_address", cmd_address, front[6:0]);
        else          check("tdata_tlast", {tlast, tdata}, front[8:0]);
      end else begin
        check("valid_idle", {cmd_valid, tvalid}, 2'b00);
      end
      if (busy && !busy_prev) busy_rises++;
      busy_prev = busy;
    end
  end

  // ---------------- ready driver ----------------
  always @(negedge clk) begin
    #1;
    if (rdy_mode == 0) begin
      cmd_ready = 1'b1;
      tready    = 1'b1;
    end else if (rdy_mode == 1) begin
      cmd_ready = ($urandom_range(0, 9) < 3);
      tready    = ($urandom_range(0, 9) < 3);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k;
    k = 0;
    while (busy && k < budget) begin
      tick(1);
      k++;
    end
    check(name, busy, 1'b0);
  endtask

  task automatic check_stream(input string name);
    check(name, cap_q.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < cap_q.size()) check(name, cap_q[i], lit_stream[i]);
    end
  endtask

  task automatic check_all_zero(input string name);
    check(name, {busy, cmd_valid, cmd_wm, cmd_stop, tvalid, tlast}, 6'd0);
    check(name, {cmd_address, tdata, dbg_state}, 17'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int bcnt;
    int c0;
    int r0;
    bit found;

    lit_stream = '{9'h000, 9'h101, 9'h001, 9'h102, 9'h002, 9'h104, 9'h003, 9'h108};

    // Reset
    rst = 1'b1;
    tick(10);
    check_all_zero("reset_outputs");
    cmp_en = 1'b1;
    rst = 1'b0;
    tick(2);

    // Single pass, ready tied high
    rdy_mode = 0;
    cap_q.delete();
    start = 1'b1;
    tick(1);
    check("latency_cmd_valid", cmd_valid, 1'b1);
    check("first_address", cmd_address, 7'h50);
    check("first_wm_stop", {cmd_wm, cmd_stop}, 2'b11);
    bcnt = 0;
    while (busy && bcnt < 100) begin
      bcnt++;
      tick(1);
    end
    check("pass_length", bcnt, 3 * N_ENT);
    check_stream("stream_ready_high");
    start = 1'b0;
    tick(3);

    // Back-pressure
    rdy_mode = 1;
    cap_q.delete();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_idle(600, "backpressure_timeout");
    check_stream("stream_backpressure");
    tick(3);

    // Start edges while busy
    c0 = cmd_xfers;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    bcnt = 0;
    while (busy && bcnt < 600) begin
      start = $urandom_range(0, 1);
      tick(1);
      bcnt++;
    end
    start = 1'b0;
    check("start_busy_timeout", busy, 1'b0);
    tick(4);
    check("cmds_one_pass", cmd_xfers - c0, N_ENT);

    // Start held across reset release
    rdy_mode = 0;
    rst = 1'b1;
    start = 1'b1;
    tick(5);
    r0 = busy_rises;
    rst = 1'b0;
    tick(60);
    check("level_hold_passes", busy_rises - r0, 1);
    start = 1'b0;
    tick(3);
    cap_q.delete();
    start = 1'b1;
    tick(1);
    wait_idle(100, "rerun_timeout");
    check("rerun_passes", busy_rises - r0, 2);
    check_stream("stream_rerun");
    start = 1'b0;
    tick(3);

    // Reset during REG of entry 2
    rdy_mode = 1;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    found = 1'b0;
    bcnt = 0;
    while (!found && bcnt < 600) begin
      if (tvalid && !tlast && tdata == 8'h02) found = 1'b1;
      else begin
        tick(1);
        bcnt++;
      end
    end
    check("found_reg_entry2", found, 1'b1);
    rst = 1'b1;
    tick(1);
    check_all_zero("midpass_reset");
    rst = 1'b0;
    tick(2);
    check("idle_after_reset", busy, 1'b0);
    cap_q.delete();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_idle(600, "restart_timeout");
    check_stream("stream_restart");

    // Randomized start / ready mix
    for (int it = 0; it < 8; it++) begin
      rdy_mode = $urandom_range(0, 1);
      for (int c = 0; c < 120; c++) begin
        start = ($urandom_range(0, 7) == 0);
        tick(1);
      end
    end
    start = 1'b0;
    rdy_mode = 0;
    wait_idle(200, "random_final_timeout");
    tick(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
